// File: rtl/multi_channel_debouncer.sv
// Per-channel synchroniser + stability filter with registered level and one-cycle rise/fall strobes.
// Optional per-channel rejected-glitch counters when MULTI_DEBOUNCER_GLITCH_COUNT_EN is defined.
module multi_channel_debouncer #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W         = 20,
  parameter int SYNC_STAGES   = 2,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in_raw,
  output logic [CHANNELS-1:0] out_level,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                any_change
`ifdef MULTI_DEBOUNCER_GLITCH_COUNT_EN
  ,
  output logic [CHANNELS*GLITCH_W-1:0] glitch_count
`endif
);

  if (CHANNELS < 1 || STABLE_CYCLES < 2 || SYNC_STAGES < 2 || GLITCH_W < 1 ||
      (64'(1) << CNT_W) <= 64'(STABLE_CYCLES - 1)) begin : g_bad_params
    $error("multi_channel_debouncer: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0][CNT_W-1:0]       cnt_q;
  logic [CHANNELS-1:0]                  sync;
  logic [CHANNELS-1:0]                  mismatch;
  logic [CHANNELS-1:0]                  qualify;

  assign sync     = sync_q[SYNC_STAGES-1];
  assign mismatch = sync ^ out_level;

  always_comb begin
    qualify = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      qualify[i] = mismatch[i] && (cnt_q[i] == CNT_MAX);
    end
  end

  // Stage 0 samples the pins; the last stage feeds the filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_raw};
    end
  end

  // Any return to equality restarts the count, so bounces never accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      out_level  <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
      any_change <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!mismatch[i] || qualify[i]) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
      out_level  <= out_level ^ qualify;
      rise_pulse <= qualify & sync;
      fall_pulse <= qualify & ~sync;
      any_change <= |qualify;
    end
  end

`ifdef MULTI_DEBOUNCER_GLITCH_COUNT_EN
  logic [CHANNELS-1:0][GLITCH_W-1:0] glitch_q;

  // A glitch is a mismatch that collapsed back to equality before qualifying.
  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!mismatch[i] && (cnt_q[i] != '0) && (glitch_q[i] != '1)) begin
          glitch_q[i] <= glitch_q[i] + 1'b1;
        end
      end
    end
  end

  assign glitch_count = glitch_q;
`endif

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Directed bench: table of per-edge vectors plus hand sequences for bounce and mid-count reset.
module tb_multi_channel_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_raw;
  logic [3:0] out_level, rise_pulse, fall_pulse;
  logic       any_change;
`ifdef MULTI_DEBOUNCER_GLITCH_COUNT_EN
  logic [31:0] glitch_count;
`endif

  int checks   = 0;
  int failures = 0;

  multi_channel_debouncer #(
    .CHANNELS(4), .STABLE_CYCLES(4), .CNT_W(2), .SYNC_STAGES(2), .GLITCH_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_raw(in_raw),
    .out_level(out_level),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .any_change(any_change)
`ifdef MULTI_DEBOUNCER_GLITCH_COUNT_EN
    ,
    .glitch_count(glitch_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] in;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(string name, logic r, logic [3:0] in, logic [3:0] lvl,
                              logic [3:0] rise, logic [3:0] fall, logic any);
    vec_t v;
    v.name = name; v.rst = r; v.in = in; v.lvl = lvl;
    v.rise = rise; v.fall = fall; v.any = any;
    tbl.push_back(v);
  endfunction

  task automatic check_outs(string name, logic [3:0] lvl, logic [3:0] rise,
                            logic [3:0] fall, logic any);
    checks++;
    if (out_level !== lvl || rise_pulse !== rise || fall_pulse !== fall || any_change !== any) begin
      failures++;
      $display("FAIL %s: got lvl=%b rise=%b fall=%b any=%b, want lvl=%b rise=%b fall=%b any=%b",
               name, out_level, rise_pulse, fall_pulse, any_change, lvl, rise, fall, any);
    end
  endtask

  task automatic step(logic r, logic [3:0] in);
    rst    = r;
    in_raw = in;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] bounce [12];
    logic [3:0] exp_lvl;

    // Reset
    add("reset0", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    add("reset1", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    // Clean press on ch0: update on the 6th edge after the change
    for (int e = 1; e <= 5; e++)
      add($sformatf("press_e%0d", e), 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0);
    add("press_e6", 0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1);
    add("press_e7", 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);
    // 3-cycle glitch on ch1 must be rejected
    for (int e = 1; e <= 3; e++)
      add($sformatf("glitch_hi%0d", e), 0, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 0);
    for (int e = 1; e <= 4; e++)
      add($sformatf("glitch_lo%0d", e), 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);
    // Release of ch0
    for (int e = 1; e <= 5; e++)
      add($sformatf("release_e%0d", e), 0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 0);
    add("release_e6", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1);
    add("release_e7", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    // All channels together
    for (int e = 1; e <= 5; e++)
      add($sformatf("simul_e%0d", e), 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0);
    add("simul_e6", 0, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1);
    add("simul_e7", 0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 0);
    for (int e = 1; e <= 5; e++)
      add($sformatf("simul_rel_e%0d", e), 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 0);
    add("simul_rel_e6", 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1);
    add("simul_rel_e7", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);

    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].in);
      check_outs(tbl[k].name, tbl[k].lvl, tbl[k].rise, tbl[k].fall, tbl[k].any);
    end

`ifdef MULTI_DEBOUNCER_GLITCH_COUNT_EN
    checks++;
    if (glitch_count !== 32'h0000_0100) begin
      failures++;
      $display("FAIL glitch_count: got %h want %h", glitch_count, 32'h0000_0100);
    end
`endif

    // Bounce on ch2: 1,0,1,0 then 1 held; final rising sample at k=4, update at k=9
    bounce = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0100,
               4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
    for (int k = 0; k < 12; k++) begin
      step(0, bounce[k]);
      exp_lvl = (k >= 9) ? 4'b0100 : 4'b0000;
      check_outs($sformatf("bounce_k%0d", k), exp_lvl, (k == 9) ? 4'b0100 : 4'b0000,
                 4'b0000, k == 9);
    end

    // Reset mid-count on ch3; reset also clears ch2's level. Requalify 6 edges after release.
    for (int k = 0; k < 11; k++) begin
      step(k == 3, 4'b1100);
      if (k < 3)      exp_lvl = 4'b0100;
      else if (k < 9) exp_lvl = 4'b0000;
      else            exp_lvl = 4'b1100;
      check_outs($sformatf("rst_mid_k%0d", k), exp_lvl, (k == 9) ? 4'b1100 : 4'b0000,
                 4'b0000, k == 9);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
